// File: rtl/int_to_flp_scheduler.sv
// int_to_flp_scheduler: round-robin owner of one int-to-fp pass unit for two requesters
// Optional RUN watchdog with sticky err: define INTTOFLP_SCHED_WATCHDOG_EN
`ifndef EXPONENT_BITS
`define EXPONENT_BITS 8
`endif
module int_to_flp_scheduler #(
    parameter int LOGN = 13,
    parameter int M = 17,
    parameter int PIPE_LAT = 4,
    parameter int SP_W = `EXPONENT_BITS + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      current_n,
    input  logic [1:0]      req,
    input  logic [M-1:0]    req0_q_m,
    input  logic [SP_W-1:0] req0_scale_power,
    input  logic [M-1:0]    req1_q_m,
    input  logic [SP_W-1:0] req1_scale_power,
    output logic [1:0]      grant,
    output logic [1:0]      done_req,
    output logic            busy,
    output logic            bank_sel,
    output logic            conv_rst,
    output logic [M-1:0]    conv_q_m,
    output logic [SP_W-1:0] conv_scale_power,
    input  logic            conv_done,
    output logic            err
);
    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DRAIN} state_t;
    localparam int DW = $clog2(PIPE_LAT) + 1;
    state_t state, state_nx;
    logic [DW-1:0] dcnt;
    logic [1:0] n_lat;
    logic rr, w, last, timeout;
    always_comb begin
        w = req[1] && !(req[0] && rr);
        last = dcnt == DW'(PIPE_LAT - 1);
        state_nx = state;
        case (state)
            IDLE: state_nx = |req ? CLEAR : IDLE;
            CLEAR: state_nx = RUN;
            RUN: state_nx = (conv_done || timeout) ? DRAIN : RUN;
            default: state_nx = last ? IDLE : DRAIN;
        endcase
        busy = state != IDLE;
        conv_rst = state != RUN;
        grant = state == CLEAR ? {bank_sel, !bank_sel} : 2'b00;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rr <= 1'b1;
            bank_sel <= 1'b0;
            conv_q_m <= '0;
            conv_scale_power <= '0;
            n_lat <= '0;
            dcnt <= '0;
            done_req <= 2'b00;
        end else begin
            state <= state_nx;
            dcnt <= state == DRAIN ? dcnt + 1'b1 : '0;
            done_req <= (state == DRAIN && last) ? {bank_sel, !bank_sel} : 2'b00;
            if (state == IDLE && |req) begin
                bank_sel <= w;
                rr <= w;
                conv_q_m <= w ? req1_q_m : req0_q_m;
                conv_scale_power <= w ? req1_scale_power : req0_scale_power;
                n_lat <= current_n;
            end
        end
    end
`ifdef INTTOFLP_SCHED_WATCHDOG_EN
    localparam int CW = LOGN + 4;
    logic [CW-1:0] run_cnt, lim;
    // run_cnt is zero in the first RUN cycle, so lim holds N+PIPE_LAT+16-1
    assign lim = (CW'(1) << (LOGN + int'(n_lat))) + CW'(PIPE_LAT + 15);
    assign timeout = state == RUN && !conv_done && run_cnt == lim;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt <= '0;
            err <= 1'b0;
        end else begin
            run_cnt <= state == RUN ? run_cnt + 1'b1 : '0;
            err <= err | timeout;
        end
    end
`else
    logic unused_n;
    assign timeout = 1'b0;
    assign err = 1'b0;
    assign unused_n = ^n_lat;
`endif
endmodule

// File: tb/tb_int_to_flp_scheduler.sv
// tb_int_to_flp_scheduler: scoreboard bench; expected grants/done timing queued when a request is driven
module tb_int_to_flp_scheduler;
    localparam int M = 17;
    localparam int SP_W = 9;
    localparam int P = 4;
    typedef struct {
        logic [1:0]      g;
        logic [M-1:0]    q;
        logic [SP_W-1:0] sp;
        int              lat;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] current_n = 2'd0;
    logic [1:0] req = 2'b00;
    logic [M-1:0] req0_q_m = '0, req1_q_m = '0;
    logic [SP_W-1:0] req0_sp = '0, req1_sp = '0;
    logic [1:0] grant, done_req;
    logic busy, bank_sel, conv_rst, conv_done, err;
    logic [M-1:0] conv_q_m;
    logic [SP_W-1:0] conv_sp;
    int vectors = 0, miscompares = 0;
    int cyc = 0, last_grant_cyc = 0, last_done_cyc = 0;
    int ccnt = 0, conv_len = 8196;
    bit stall = 1'b0, job_open = 1'b0;
    exp_t exp_q[$];
    exp_t cur;

    int_to_flp_scheduler #(.LOGN(13), .M(M), .PIPE_LAT(P), .SP_W(SP_W)) dut (
        .clk(clk), .rst(rst), .current_n(current_n), .req(req),
        .req0_q_m(req0_q_m), .req0_scale_power(req0_sp),
        .req1_q_m(req1_q_m), .req1_scale_power(req1_sp),
        .grant(grant), .done_req(done_req), .busy(busy), .bank_sel(bank_sel),
        .conv_rst(conv_rst), .conv_q_m(conv_q_m), .conv_scale_power(conv_sp),
        .conv_done(conv_done), .err(err)
    );

    always #5 clk = ~clk;

    // converter stand-in: done after conv_len cycles out of restart, cleared by conv_rst
    always @(posedge clk) ccnt <= conv_rst ? 0 : ccnt + 1;
    assign conv_done = !stall && !conv_rst && (ccnt >= conv_len - 1);

    // advance one cycle; pop/compare the scoreboard on grant and done pulses
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (rst) job_open = 1'b0;
        else begin
            if (grant !== 2'b00) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL grant_unexpected got=%b want=none", grant);
                end else begin
                    e = exp_q.pop_front();
                    if (grant !== e.g || conv_q_m !== e.q || conv_sp !== e.sp) begin
                        miscompares++;
                        $display("FAIL grant_cfg got=%b/%h/%0d want=%b/%h/%0d", grant, conv_q_m, conv_sp, e.g, e.q, e.sp);
                    end
                    cur = e;
                    job_open = 1'b1;
                    last_grant_cyc = cyc;
                end
            end
            if (done_req !== 2'b00) begin
                vectors++;
                if (!job_open || done_req !== cur.g || cyc - last_grant_cyc != cur.lat || conv_q_m !== cur.q || conv_sp !== cur.sp) begin
                    miscompares++;
                    $display("FAIL done_req got=%b at +%0d open=%0d want=%b at +%0d", done_req, cyc - last_grant_cyc, job_open, cur.g, cur.lat);
                end
                job_open = 1'b0;
                last_done_cyc = cyc;
            end
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        vectors++;
        if ({grant, done_req, busy, bank_sel, conv_rst, conv_q_m, conv_sp, err} !== {2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 17'h0, 9'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state got=%b/%b/%b/%b/%b/%h/%0d/%b", grant, done_req, busy, bank_sel, conv_rst, conv_q_m, conv_sp, err);
        end
        rst = 1'b0;
    endtask

    // also covers config stability: req0 config and current_n change mid-RUN
    task automatic test_single_job();
        int low = 0, bank_bad = 0, cfg_bad = 0;
        bit seen = 1'b0;
        conv_len = 8192 + P;
        current_n = 2'd0;
        req0_q_m = 17'h1ABCD;
        req0_sp = 9'd40;
        req = 2'b01;
        exp_q.push_back('{2'b01, 17'h1ABCD, 9'd40, 8201});
        tick();
        vectors++;
        if (grant !== 2'b01) begin
            miscompares++;
            $display("FAIL single_grant got=%b want=01", grant);
        end
        req = 2'b00;
        for (int i = 0; i < 9000 && !seen; i++) begin
            if (i == 100) begin
                req0_q_m = 17'h00F0F;
                req0_sp = 9'd3;
                current_n = 2'd2;
            end
            tick();
            seen = done_req !== 2'b00;
            low += int'(conv_rst === 1'b0);
            bank_bad += int'(bank_sel !== 1'b0);
            cfg_bad += int'(conv_q_m !== 17'h1ABCD || conv_sp !== 9'd40);
        end
        current_n = 2'd0;
        vectors += 4;
        if (!seen) begin
            miscompares++;
            $display("FAIL single_timeout got=no_done want=done");
        end
        if (low != 8196) begin
            miscompares++;
            $display("FAIL single_run_len got=%0d want=8196", low);
        end
        if (bank_bad != 0) begin
            miscompares++;
            $display("FAIL single_bank_sel got=%0d_bad want=0", bank_bad);
        end
        if (cfg_bad != 0) begin
            miscompares++;
            $display("FAIL config_stability got=%0d_bad want=0", cfg_bad);
        end
    endtask

    // scheduler timing depends only on conv_done, so a short converter keeps this brief
    task automatic test_round_robin();
        int grants = 0, prev_grant = 0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        conv_len = 64 + P;
        req0_q_m = 17'h00111;
        req0_sp = 9'd1;
        req1_q_m = 17'h1FFFF;
        req1_sp = 9'd2;
        req = 2'b11;
        exp_q.push_back('{2'b01, 17'h00111, 9'd1, 64 + 2 * P + 1});
        exp_q.push_back('{2'b10, 17'h1FFFF, 9'd2, 64 + 2 * P + 1});
        exp_q.push_back('{2'b01, 17'h00111, 9'd1, 64 + 2 * P + 1});
        for (int i = 0; i < 1000 && (grants < 3 || job_open); i++) begin
            tick();
            if (grant !== 2'b00) begin
                grants++;
                if (grants > 1) begin
                    vectors++;
                    if (!(last_done_cyc > prev_grant && last_grant_cyc - last_done_cyc >= 1)) begin
                        miscompares++;
                        $display("FAIL rr_gap got=%0d want>=1", last_grant_cyc - last_done_cyc);
                    end
                end
                prev_grant = last_grant_cyc;
                if (grants == 3) req = 2'b00;
            end
        end
        req = 2'b00;
        vectors++;
        if (grants != 3 || job_open || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rr_count got=%0d_grants want=3", grants);
        end
    endtask

    task automatic test_reset_mid_run();
        int dn = 0;
        conv_len = 8192 + P;
        req0_q_m = 17'h0AAAA;
        req0_sp = 9'd5;
        req = 2'b01;
        exp_q.push_back('{2'b01, 17'h0AAAA, 9'd5, 8201});
        tick();
        vectors++;
        if (grant !== 2'b01) begin
            miscompares++;
            $display("FAIL abort_grant got=%b want=01", grant);
        end
        req = 2'b00;
        repeat (100) tick();
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({grant, done_req, busy, bank_sel, conv_rst, conv_q_m, conv_sp} !== {2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 17'h0, 9'h0}) begin
            miscompares++;
            $display("FAIL async_reset got=%b/%b/%b/%b/%b/%h/%0d", grant, done_req, busy, bank_sel, conv_rst, conv_q_m, conv_sp);
        end
        tick();
        tick();
        rst = 1'b0;
        repeat (300) begin
            tick();
            dn += int'(done_req !== 2'b00);
        end
        vectors++;
        if (dn != 0) begin
            miscompares++;
            $display("FAIL abort_no_done got=%0d want=0", dn);
        end
    endtask

    // first job here is the req=10 request right after the aborted job
    task automatic test_sizes();
        bit seen;
        for (int n = 1; n <= 2; n++) begin
            seen = 1'b0;
            current_n = 2'(n);
            conv_len = (8192 << n) + P;
            req0_q_m = 17'h12345;
            req0_sp = 9'd7;
            req1_q_m = 17'h0BEEF;
            req1_sp = 9'd300;
            req = n == 1 ? 2'b10 : 2'b01;
            exp_q.push_back(n == 1 ? '{2'b10, 17'h0BEEF, 9'd300, 16393} : '{2'b01, 17'h12345, 9'd7, 32777});
            tick();
            vectors++;
            if (grant !== req) begin
                miscompares++;
                $display("FAIL size_grant n=%0d got=%b want=%b", n, grant, req);
            end
            req = 2'b00;
            for (int i = 0; i < conv_len + 50 && !seen; i++) begin
                tick();
                seen = done_req !== 2'b00;
            end
            vectors++;
            if (!seen) begin
                miscompares++;
                $display("FAIL size_timeout n=%0d got=no_done want=done", n);
            end
        end
        current_n = 2'd0;
    endtask

`ifdef INTTOFLP_SCHED_WATCHDOG_EN
    task automatic test_watchdog();
        int first_err = -1;
        bit seen = 1'b0;
        conv_len = 8192 + P;
        stall = 1'b1;
        req0_q_m = 17'h00042;
        req0_sp = 9'd9;
        req = 2'b01;
        exp_q.push_back('{2'b01, 17'h00042, 9'd9, 8192 + P + 16 + P + 1});
        tick();
        req = 2'b00;
        for (int i = 0; i < 8400 && !seen; i++) begin
            tick();
            if (err === 1'b1 && first_err < 0) first_err = cyc - last_grant_cyc;
            seen = done_req !== 2'b00;
        end
        repeat (10) tick();
        vectors += 3;
        if (!seen) begin
            miscompares++;
            $display("FAIL wd_timeout got=no_done want=done");
        end
        if (first_err != 8192 + P + 16 + 1) begin
            miscompares++;
            $display("FAIL wd_err_time got=%0d want=%0d", first_err, 8192 + P + 16 + 1);
        end
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL wd_err_sticky got=%b want=1", err);
        end
        stall = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL wd_err_clear got=%b want=0", err);
        end
    endtask
`else
    task automatic test_watchdog();
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_tied got=%b want=0", err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_job();
        test_round_robin();
        test_reset_mid_run();
        test_sizes();
        test_watchdog();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
